// File: rtl/iq_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iq_sched_pkg
//  Purpose  : Shared types and constants for the I/Q filter scheduler.
//             Holds the scheduler state type and the default sample width.
//  Revision : 1.0  initial release
// ============================================================================
package iq_sched_pkg;

    // Default sample width for filter input/output and I/Q data.
    localparam int DATA_W = 5;

    // Scheduler states. IDLE must stay at zero so that busy = (state != IDLE).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_I = 3'd1,
        ST_WAIT_I = 3'd2,
        ST_SEND_Q = 3'd3,
        ST_WAIT_Q = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/iq_filter_scheduler_tick.sv
`default_nettype none
// ============================================================================
//  Module   : sample_tick_gen
//  Purpose  : Programmable sample-rate divider. Issues a one-cycle tick every
//             max(div_cfg,1) clock cycles while enable is high.
//  Ports    : clk, reset (async, active-high)
//             enable   - 1 = count and issue ticks; 0 = count held at zero
//             div_cfg  - tick period in clk cycles, 0 behaves like 1
//             tick     - one-cycle strobe, combinational from the count
//  Revision : 1.0  initial release
// ============================================================================
module sample_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] w_period_m1;

    // Last count value of a period; div_cfg of 0 collapses to a period of 1.
    assign w_period_m1 = (div_cfg == '0) ? '0 : div_cfg - DIV_W'(1);

    assign tick = enable && (r_count == w_period_m1);

    // Using >= rather than == lets a shrunken div_cfg wrap the count to zero
    // silently when the count has already run past the new period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!enable) begin
            r_count <= '0;
        end else if (r_count >= w_period_m1) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_filter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : iq_filter_scheduler
//  Purpose  : Time-multiplexes one shared low-pass filter between the I and Q
//             channels. On each divider tick an I/Q pair is latched, I then Q
//             is pushed through the filter over a valid/ready handshake, and
//             the two results are published with a one-cycle out_valid.
//  Ports    : clk, reset (async, active-high)
//             enable, div_cfg        - sample-rate divider control
//             clr_flags              - clears sticky overrun/timeout
//             i_in, q_in             - samples from the mixer
//             filt_data_in/valid     - registered request to the filter
//             filt_ready             - filter accepts request
//             filt_data_out/done     - filter result strobe
//             i_out, q_out, out_valid- published pair
//             busy, overrun, timeout - status
//  Revision : 1.0  initial release
// ============================================================================
module iq_filter_scheduler #(
    parameter int DATA_W  = iq_sched_pkg::DATA_W,
    parameter int DIV_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_cfg,
    input  logic              clr_flags,
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] q_in,
    output logic [DATA_W-1:0] filt_data_in,
    output logic              filt_valid,
    input  logic              filt_ready,
    input  logic [DATA_W-1:0] filt_data_out,
    input  logic              filt_done,
    output logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] q_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    import iq_sched_pkg::sched_state_t;
    import iq_sched_pkg::ST_IDLE;
    import iq_sched_pkg::ST_SEND_I;
    import iq_sched_pkg::ST_WAIT_I;
    import iq_sched_pkg::ST_SEND_Q;
    import iq_sched_pkg::ST_WAIT_Q;

    // Wait counter spans 0..TIMEOUT-1; the abort fires on the last value.
    localparam int                c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    sched_state_t        r_state;
    logic [DATA_W-1:0]   r_q_lat;
    logic [DATA_W-1:0]   r_i_res;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic w_tick;
    logic w_waiting;
    logic w_wait_expire;
    logic w_overrun_set;

    sample_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .div_cfg (div_cfg),
        .tick    (w_tick)
    );

    assign busy      = (r_state != ST_IDLE);
    assign w_waiting = (r_state == ST_WAIT_I) || (r_state == ST_WAIT_Q);

    // A result arriving on the final allowed cycle still counts as on time.
    assign w_wait_expire = w_waiting && !filt_done && (r_wait_cnt == c_WAIT_LAST);

    assign w_overrun_set = w_tick && (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_q_lat      <= '0;
            r_i_res      <= '0;
            r_wait_cnt   <= '0;
            filt_data_in <= '0;
            filt_valid   <= 1'b0;
            i_out        <= '0;
            q_out        <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            // Sticky flags: a set in the same cycle as a clear takes priority.
            if (w_overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end

            if (w_wait_expire) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        // filt_data_in doubles as the I sample latch.
                        filt_data_in <= i_in;
                        r_q_lat      <= q_in;
                        filt_valid   <= 1'b1;
                        r_state      <= ST_SEND_I;
                    end
                end

                ST_SEND_I: begin
                    if (filt_ready) begin
                        filt_valid <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT_I;
                    end
                end

                ST_WAIT_I: begin
                    if (filt_done) begin
                        r_i_res      <= filt_data_out;
                        filt_data_in <= r_q_lat;
                        filt_valid   <= 1'b1;
                        r_state      <= ST_SEND_Q;
                    end else if (w_wait_expire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end

                ST_SEND_Q: begin
                    if (filt_ready) begin
                        filt_valid <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT_Q;
                    end
                end

                ST_WAIT_Q: begin
                    if (filt_done) begin
                        i_out     <= r_i_res;
                        q_out     <= filt_data_out;
                        out_valid <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_wait_expire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end

                default: begin
                    filt_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iq_filter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iq_filter_scheduler
//  Purpose  : Self-checking bench for iq_filter_scheduler: vector table for
//             latency/data, hand sequences for corner cases, and a randomized
//             run against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iq_filter_scheduler;

    localparam int DATA_W  = 5;
    localparam int DIV_W   = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DIV_W-1:0]  div_cfg;
    logic              clr_flags;
    logic [DATA_W-1:0] i_in;
    logic [DATA_W-1:0] q_in;
    logic [DATA_W-1:0] filt_data_in;
    logic              filt_valid;
    logic              filt_ready;
    logic [DATA_W-1:0] filt_data_out;
    logic              filt_done;
    logic [DATA_W-1:0] i_out;
    logic [DATA_W-1:0] q_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic              timeout;

    always #5 clk = ~clk;

    iq_filter_scheduler #(
        .DATA_W  (DATA_W),
        .DIV_W   (DIV_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .div_cfg       (div_cfg),
        .clr_flags     (clr_flags),
        .i_in          (i_in),
        .q_in          (q_in),
        .filt_data_in  (filt_data_in),
        .filt_valid    (filt_valid),
        .filt_ready    (filt_ready),
        .filt_data_out (filt_data_out),
        .filt_done     (filt_done),
        .i_out         (i_out),
        .q_out         (q_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Filter model state
    int                f_k    = 1;
    logic [DATA_W-1:0] f_mask = '0;
    bit                f_drop = 1'b0;
    bit                f_spur = 1'b0;
    bit                f_pend = 1'b0;
    int                f_cnt  = 0;
    logic [DATA_W-1:0] f_data = '0;
    int                n_xfer = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // One clock: sample the handshake before the edge, then run the filter
    // model (fixed latency f_k, result = sample ^ f_mask) after it.
    task automatic step();
        logic              xfer;
        logic [DATA_W-1:0] xd;
        @(negedge clk);
        xfer = filt_valid && filt_ready;
        xd   = filt_data_in;
        @(posedge clk);
        #1;
        cyc++;
        filt_done     = 1'b0;
        filt_data_out = DATA_W'($urandom);
        if (xfer) begin
            n_xfer++;
            if (!f_drop) begin
                f_pend = 1'b1;
                f_cnt  = f_k;
                f_data = xd ^ f_mask;
            end
        end
        if (f_pend) begin
            f_cnt--;
            if (f_cnt == 0) begin
                filt_done     = 1'b1;
                filt_data_out = f_data;
                f_pend        = 1'b0;
            end
        end else if (f_spur && !xfer && $urandom_range(0, 7) == 0) begin
            filt_done = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        clr_flags  = 1'b0;
        filt_ready = 1'b1;
        filt_done  = 1'b0;
        f_pend     = 1'b0;
        f_drop     = 1'b0;
        f_spur     = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_out_valid(input string name, input int maxc);
        bit got;
        got = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            step();
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_out_valid_seen"}, int'(got), 1);
    endtask

    task automatic wait_filt_valid(input string name, input int maxc);
        bit got;
        got = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            step();
            if (filt_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_filt_valid_seen"}, int'(got), 1);
    endtask

    typedef struct {
        int div; int k; int iv; int qv; int mask;
        int lat; int ivl; int ei; int eq; int eovr;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int   e;
        int   t1;
        int   cnt_ov;
        int   cnt_busy;
        // reference model state for randomized run
        int   m_cnt, m_pub, m_iout, m_qout, p_i, p_q, pm1, k;
        bit   m_act, m_ovr, tk, was_act, exp_ov;

        // div, k, i, q, mask, latency-from-enable, publish interval, i_out, q_out, overrun
        vt[0] = '{4,  2,  3,  7,  0, 10,  8,  3,  7, 1};
        vt[1] = '{10, 1, 31,  0,  0, 14, 10, 31,  0, 0};
        vt[2] = '{1,  3, 21, 10, 31,  9,  9, 10, 21, 1};
        vt[3] = '{0,  1,  0, 31, 10,  5,  5, 10, 21, 1};
        vt[4] = '{12, 4, 17, 14, 17, 22, 12,  0, 31, 0};

        div_cfg = '0; i_in = '0; q_in = '0; filt_data_out = '0;
        do_reset();

        // Reset state
        check("rst_filt_valid", int'(filt_valid), 0);
        check("rst_filt_data_in", int'(filt_data_in), 0);
        check("rst_i_out", int'(i_out), 0);
        check("rst_q_out", int'(q_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout", int'(timeout), 0);

        // Table: latency, data pass-through, publish interval, overrun
        for (int v = 0; v < 5; v++) begin
            do_reset();
            div_cfg = DIV_W'(vt[v].div);
            f_k     = vt[v].k;
            f_mask  = DATA_W'(vt[v].mask);
            i_in    = DATA_W'(vt[v].iv);
            q_in    = DATA_W'(vt[v].qv);
            enable  = 1'b1;
            e       = cyc;
            wait_out_valid("vec_first", 100);
            check("vec_latency", cyc - e, vt[v].lat);
            check("vec_i_out", int'(i_out), vt[v].ei);
            check("vec_q_out", int'(q_out), vt[v].eq);
            t1 = cyc;
            wait_out_valid("vec_second", 100);
            check("vec_interval", cyc - t1, vt[v].ivl);
            check("vec_overrun", int'(overrun), vt[v].eovr);
        end

        // Overrun with div_cfg=0 and clear/set priority
        do_reset();
        div_cfg = '0; f_k = 1; f_mask = '0; i_in = 5'd5; q_in = 5'd6;
        enable = 1'b1;
        step();
        step();
        check("ovr_set", int'(overrun), 1);
        clr_flags = 1'b1;
        step();
        check("ovr_set_beats_clr", int'(overrun), 1);
        enable = 1'b0;
        step();
        check("ovr_clr", int'(overrun), 0);
        clr_flags = 1'b0;
        wait_out_valid("ovr_pair", 20);
        check("ovr_pair_i", int'(i_out), 5);
        check("ovr_pair_q", int'(q_out), 6);

        // Backpressure: filt_ready low for 5 cycles in SEND_I
        do_reset();
        filt_ready = 1'b0;
        div_cfg = 16'd3; f_k = 2; f_mask = '0; i_in = 5'd3; q_in = 5'd7;
        n_xfer = 0;
        enable = 1'b1;
        wait_filt_valid("bp", 20);
        enable = 1'b0;
        i_in = 5'd30;
        for (int n = 0; n < 5; n++) begin
            check("bp_valid_held", int'(filt_valid), 1);
            check("bp_data_held", int'(filt_data_in), 3);
            step();
        end
        check("bp_valid_held_last", int'(filt_valid), 1);
        check("bp_no_xfer_yet", n_xfer, 0);
        filt_ready = 1'b1;
        wait_out_valid("bp_pair", 30);
        check("bp_xfer_count", n_xfer, 2);
        check("bp_i_out", int'(i_out), 3);
        check("bp_q_out", int'(q_out), 7);

        // Timeout: filter never answers
        do_reset();
        div_cfg = 16'd2; f_k = 1; f_mask = '0; i_in = 5'd9; q_in = 5'd4;
        enable = 1'b1;
        wait_out_valid("to_pre", 20);
        enable = 1'b0;
        step();
        f_drop = 1'b1; i_in = 5'd1; q_in = 5'd2;
        enable = 1'b1;
        wait_filt_valid("to", 20);
        enable = 1'b0;
        cnt_ov = 0;
        for (int n = 1; n <= TIMEOUT + 1; n++) begin
            step();
            if (out_valid) cnt_ov++;
            if (n == TIMEOUT) begin
                check("to_not_yet", int'(timeout), 0);
                check("to_busy_before", int'(busy), 1);
            end
            if (n == TIMEOUT + 1) begin
                check("to_flag", int'(timeout), 1);
                check("to_idle", int'(busy), 0);
            end
        end
        check("to_no_out_valid", cnt_ov, 0);
        check("to_i_kept", int'(i_out), 9);
        check("to_q_kept", int'(q_out), 4);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("to_clr", int'(timeout), 0);
        f_drop = 1'b0;

        // Asynchronous reset during WAIT_Q
        do_reset();
        div_cfg = 16'd2; f_k = 4; f_mask = '0; i_in = 5'd12; q_in = 5'd19;
        n_xfer = 0;
        enable = 1'b1;
        wait_out_valid("ar_pre", 40);
        for (int n = 0; n < 60 && n_xfer < 4; n++) step();
        check("ar_reached_wait_q", n_xfer, 4);
        check("ar_busy", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_filt_valid", int'(filt_valid), 0);
        check("ar_filt_data_in", int'(filt_data_in), 0);
        check("ar_i_out", int'(i_out), 0);
        check("ar_q_out", int'(q_out), 0);
        check("ar_out_valid", int'(out_valid), 0);
        check("ar_busy_low", int'(busy), 0);
        check("ar_overrun", int'(overrun), 0);
        check("ar_timeout", int'(timeout), 0);
        enable = 1'b0; f_pend = 1'b0; filt_done = 1'b0;
        step();
        step();
        reset = 1'b0;
        i_in = 5'd22; q_in = 5'd8;
        enable = 1'b1;
        e = cyc;
        wait_out_valid("ar_post", 40);
        check("ar_post_latency", cyc - e, 12);
        check("ar_post_i", int'(i_out), 22);
        check("ar_post_q", int'(q_out), 8);

        // enable dropped in SEND_Q: pair completes, then no more ticks
        do_reset();
        div_cfg = 16'd3; f_k = 2; f_mask = '0; i_in = 5'd14; q_in = 5'd25;
        n_xfer = 0;
        enable = 1'b1;
        for (int n = 0; n < 30 && !(n_xfer == 1 && filt_valid); n++) step();
        check("en_in_send_q", int'(n_xfer == 1 && filt_valid), 1);
        enable = 1'b0;
        wait_out_valid("en_pair", 20);
        check("en_i_out", int'(i_out), 14);
        check("en_q_out", int'(q_out), 25);
        cnt_ov = 0; cnt_busy = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (out_valid) cnt_ov++;
            if (busy) cnt_busy++;
        end
        check("en_no_more_pairs", cnt_ov, 0);
        check("en_stays_idle", cnt_busy, 0);
        enable = 1'b1;
        e = cyc;
        wait_out_valid("en_restart", 20);
        check("en_restart_latency", cyc - e, 9);

        // Randomized run against a transaction-level model: each accepted
        // tick at cycle t publishes at t+3+2k; any tick before that overruns.
        do_reset();
        f_spur = 1'b1;
        f_mask = DATA_W'($urandom_range(0, 31));
        div_cfg = DIV_W'($urandom_range(0, 6));
        m_cnt = 0; m_act = 1'b0; m_ovr = 1'b0; m_iout = 0; m_qout = 0;
        m_pub = 0; p_i = 0; p_q = 0;
        enable = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            step();
            exp_ov = 1'b0;
            if (m_act && cyc == m_pub) begin
                exp_ov = 1'b1;
                m_iout = p_i;
                m_qout = p_q;
                m_act  = 1'b0;
            end
            check("rnd_out_valid", int'(out_valid), int'(exp_ov));
            check("rnd_busy", int'(busy), int'(m_act));
            check("rnd_i_out", int'(i_out), m_iout);
            check("rnd_q_out", int'(q_out), m_qout);
            check("rnd_overrun", int'(overrun), int'(m_ovr));
            check("rnd_timeout", int'(timeout), 0);

            if ($urandom_range(0, 63) == 0) div_cfg = DIV_W'($urandom_range(0, 7));
            enable    = ($urandom_range(0, 15) != 0);
            clr_flags = ($urandom_range(0, 7) == 0);
            i_in      = DATA_W'($urandom);
            q_in      = DATA_W'($urandom);

            pm1 = (div_cfg == '0) ? 0 : int'(div_cfg) - 1;
            tk  = enable && (m_cnt == pm1);
            if (!enable)          m_cnt = 0;
            else if (m_cnt >= pm1) m_cnt = 0;
            else                  m_cnt = m_cnt + 1;

            was_act = m_act;
            if (tk && !m_act) begin
                k     = $urandom_range(1, 4);
                f_k   = k;
                m_act = 1'b1;
                m_pub = cyc + 3 + 2 * k;
                p_i   = int'(i_in ^ f_mask);
                p_q   = int'(q_in ^ f_mask);
            end
            if (tk && was_act) m_ovr = 1'b1;
            else if (clr_flags) m_ovr = 1'b0;
        end
        f_spur = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
